// File: rtl/csa_pkg.sv
// Shared defaults and controller state type for the carry-save accumulator.
package csa_pkg;

  localparam int unsigned WIDTH_DEF = 64;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/csa_3to2.sv
// 3:2 carry-save compressor: bitwise sum plus majority carry shifted up one place.
module csa_3to2 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-1:0] w_maj;

  always_comb begin
    sum   = x ^ y ^ z;
    w_maj = (x & y) | (x & z) | (y & z);
    // Carry out of the MSB is dropped; the result is modulo 2^WIDTH.
    carry = {w_maj[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/csa_accum_ctrl.sv
// Packet accumulator: operands are summed in carry-save form and resolved
// by a single carry-propagate add once the last operand has been accepted.
module csa_accum_ctrl
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_c;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_out_sum;
  logic [WIDTH-1:0] w_csa_sum;
  logic [WIDTH-1:0] w_csa_carry;
  logic [WIDTH-1:0] w_resolve_sum;
  logic             w_accept;

  csa_3to2 #(
    .WIDTH (WIDTH)
  ) u_csa (
    .x     (r_s),
    .y     (r_c),
    .z     (in_data),
    .sum   (w_csa_sum),
    .carry (w_csa_carry)
  );

  assign w_resolve_sum = r_s + r_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ACCUM:   if (w_accept && in_last) w_next_state = RESOLVE;
      RESOLVE: w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = ACCUM;
      default: w_next_state = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == ACCUM);
    out_valid = (r_state == DONE);
    w_accept  = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s       <= '0;
      r_c       <= '0;
      r_count   <= '0;
      r_out_sum <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_s <= w_csa_sum;
            r_c <= w_csa_carry;
            if (r_count != '1) r_count <= r_count + CNT_W'(1);
          end
        end
        RESOLVE: r_out_sum <= w_resolve_sum;
        DONE: begin
          if (out_ready) begin
            r_s     <= '0;
            r_c     <= '0;
            r_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum   = r_out_sum;
  assign out_count = r_count;

endmodule
